// File: rtl/sys_pll_lock_supervisor_if.sv
// ============================================================================
// Module   : sys_pll_lock_supervisor_if
// Brief    : PLL-side and fabric-side signals of the PLL lock supervisor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sys_pll_lock_supervisor_if;
    logic        pll_locked;
    logic        pll_clk_mon;
    logic        pll_rst;
    logic        sys_reset_n;
    logic        ready;
    logic        fault;
    logic        freq_err;
    logic [15:0] edge_count;
    logic [3:0]  retry_count;

    modport master (
        input  pll_locked, pll_clk_mon,
        output pll_rst, sys_reset_n, ready, fault, freq_err, edge_count, retry_count
    );

    modport slave (
        output pll_locked, pll_clk_mon,
        input  pll_rst, sys_reset_n, ready, fault, freq_err, edge_count, retry_count
    );
endinterface

`default_nettype wire

// File: rtl/sys_pll_lock_supervisor.sv
// ============================================================================
// Module   : sys_pll_lock_supervisor
// Brief    : PLL reset sequencing, lock qualification with bounded retries,
//            fabric reset release and PLL output frequency monitoring.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int MAX_RETRY           = 3,
    parameter int GATE_CYCLES         = 100000,
    parameter int EXP_EDGES           = 1200,
    parameter int TOL_EDGES           = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    sys_pll_lock_supervisor_if.master bus
);

    localparam int TMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int TMAX   = (TMAX_A > LOCK_STABLE_CYCLES) ? TMAX_A : LOCK_STABLE_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int GW     = $clog2(GATE_CYCLES + 1);

    localparam logic [TW-1:0] RST_LAST    = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);
    localparam logic [15:0]   EXP16       = 16'(EXP_EDGES);
    localparam logic [15:0]   TOL16       = 16'(TOL_EDGES);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic [2:0]    state, state_next;
    logic [TW-1:0] timer;
    logic [3:0]    retry_count;
    logic          retry_inc;

    logic locked_meta, locked_s, mon_meta, mon_s, mon_d, mon_rise;

    logic pll_rst, sys_reset_n, ready, fault;
    logic pll_rst_nxt, sys_reset_n_nxt, ready_nxt, fault_nxt;

    logic [GW-1:0] gate_cnt;
    logic [15:0]   edge_acc, edge_total, edge_dev, edge_count;
    logic          freq_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
            mon_meta    <= 1'b0;
            mon_s       <= 1'b0;
            mon_d       <= 1'b0;
        end else begin
            locked_meta <= bus.pll_locked;
            locked_s    <= locked_meta;
            mon_meta    <= bus.pll_clk_mon;
            mon_s       <= mon_meta;
            mon_d       <= mon_s;
        end
    end

    assign mon_rise = mon_s & ~mon_d;

    // Outputs are registered from the next-state decode so the resets never glitch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_RESET_PLL;
            timer       <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_next;
            pll_rst     <= pll_rst_nxt;
            sys_reset_n <= sys_reset_n_nxt;
            ready       <= ready_nxt;
            fault       <= fault_nxt;
            if (state_next != state)
                timer <= '0;
            else if (state != S_RUN && state != S_FAULT)
                timer <= timer + TW'(1);
            if (retry_inc)
                retry_count <= retry_count + 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        retry_inc  = 1'b0;
        case (state)
            S_RESET_PLL: begin
                if (timer == RST_LAST)
                    state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s)
                    state_next = S_STABLE;
                else if (timer == TIMEOUT_LAST) begin
                    if (retry_count == RETRY_MAX)
                        state_next = S_FAULT;
                    else begin
                        retry_inc  = 1'b1;
                        state_next = S_RESET_PLL;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s)
                    state_next = S_WAIT_LOCK;
                else if (timer == STABLE_LAST)
                    state_next = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) begin
                    if (retry_count == RETRY_MAX)
                        state_next = S_FAULT;
                    else begin
                        retry_inc  = 1'b1;
                        state_next = S_RESET_PLL;
                    end
                end
            end
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_RESET_PLL;
        endcase
    end

    always_comb begin
        pll_rst_nxt     = (state_next == S_RESET_PLL) || (state_next == S_FAULT);
        sys_reset_n_nxt = (state_next == S_RUN);
        ready_nxt       = (state_next == S_RUN);
        fault_nxt       = (state_next == S_FAULT);
    end

    assign edge_total = (edge_acc == 16'hFFFF) ? edge_acc : edge_acc + {15'd0, mon_rise};
    assign edge_dev   = (edge_total >= EXP16) ? (edge_total - EXP16) : (EXP16 - edge_total);

    // Counters sit at zero outside RUN, so an interrupted window is simply dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gate_cnt   <= '0;
            edge_acc   <= '0;
            edge_count <= '0;
            freq_err   <= 1'b0;
        end else if (state != S_RUN) begin
            gate_cnt <= '0;
            edge_acc <= '0;
        end else if (gate_cnt == GATE_LAST) begin
            edge_count <= edge_total;
            freq_err   <= (edge_dev > TOL16);
            gate_cnt   <= '0;
            edge_acc   <= '0;
        end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_acc <= edge_total;
        end
    end

    assign bus.pll_rst     = pll_rst;
    assign bus.sys_reset_n = sys_reset_n;
    assign bus.ready       = ready;
    assign bus.fault       = fault;
    assign bus.freq_err    = freq_err;
    assign bus.edge_count  = edge_count;
    assign bus.retry_count = retry_count;

endmodule

`default_nettype wire
